// File: rtl/fetch_queue_unit_if.sv
// Bus bundle for fetch_queue_unit: imem request/response channel plus decode-side handshake.
interface fetch_queue_unit_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic                     imem_rsp_valid;
    logic [DATA_WIDTH-1:0]    imem_rsp_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] PCPlus4;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_addr, out_valid, instr, pc, PCPlus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_req_valid, imem_addr, out_valid, instr, pc, PCPlus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: sequential PC requests to an in-order variable-latency imem, in-flight tag
// tracking, a prefetch FIFO of {pc, instr} toward decode, and redirect with stale-response squash.
module fetch_queue_unit #(
    parameter int unsigned            ADDRESS_WIDTH   = 32,
    parameter int unsigned            DATA_WIDTH      = 32,
    parameter int unsigned            FIFO_DEPTH      = 4,
    parameter int unsigned            MAX_OUTSTANDING = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PCSrc,
    input  logic [ADDRESS_WIDTH-1:0] PCTarget,
    fetch_queue_unit_if.master       bus
);
    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    typedef enum logic {RUN, SQUASH} state_t;

    entry_t        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [AW-1:0] tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0] tag_rd;
    logic [TW-1:0] tag_wr;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    state_t        state;
    logic [AW-1:0] fetch_pc;

    logic          credit_ok;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [OW-1:0] redirect_drop;
    entry_t        head;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] ptr);
        return (ptr == TW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + TW'(1);
    endfunction

    // Issue/credit and handshake decode; stale responses are counted out of the credit.
    always_comb begin
        credit_ok     = (SW'(count) + SW'(outstanding) - SW'(drop_cnt)) < SW'(FIFO_DEPTH);
        req_valid     = rst & ~PCSrc & (outstanding < OW'(MAX_OUTSTANDING)) & credit_ok;
        req_fire      = req_valid & bus.imem_req_ready;
        rsp_fire      = bus.imem_rsp_valid & (outstanding != '0);
        head_valid    = (count != '0);
        pop           = head_valid & bus.out_ready;
        push          = rsp_fire & (state == RUN) & ~PCSrc;
        redirect_drop = outstanding - OW'(rsp_fire);
        head          = fifo_mem[rd_ptr];
    end

    // Head fields are zeroed when the queue is empty so nothing stale is visible after reset.
    always_comb begin
        bus.imem_req_valid = req_valid;
        bus.imem_addr      = fetch_pc;
        bus.out_valid      = head_valid;
        bus.instr          = head_valid ? head.instr : '0;
        bus.pc             = head_valid ? head.pc : '0;
        bus.PCPlus4        = head_valid ? (head.pc + AW'(4)) : '0;
    end

    // Tag queue storage: PC of every accepted request, popped in response order.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr] <= fetch_pc;
        end
    end

    // Prefetch FIFO storage: kept responses paired with their request PC.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{pc: tag_mem[tag_rd], instr: bus.imem_rsp_data};
        end
    end

    // Control state: PC, pointers, in-flight accounting and RUN/SQUASH tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            state       <= RUN;
        end else begin
            if (req_fire) begin
                tag_wr   <= tag_next(tag_wr);
                fetch_pc <= fetch_pc + AW'(4);
            end
            if (rsp_fire) begin
                tag_rd <= tag_next(tag_rd);
            end
            case ({req_fire, rsp_fire})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase

            if (PCSrc) begin
                // Everything still in flight, minus a response landing now, is stale.
                fetch_pc <= {PCTarget[AW-1:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop_cnt <= redirect_drop;
                state    <= (redirect_drop != '0) ? SQUASH : RUN;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (rsp_fire && (state == SQUASH)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                    state    <= (drop_cnt == OW'(1)) ? RUN : SQUASH;
                end
            end
        end
    end
endmodule
